mmio_bridge_n: RTL and testbench
================================

Name: mmio_bridge_n

Overview:
- Parametrised memory-mapped I/O bridge between the CPU memory stage and NUM_DEV peripherals.
- Decodes the address, checks access legality, and runs a registered req/ack transaction to the selected device.
- Stalls the pipeline while a device transaction is outstanding and converts a device timeout into an address exception.
- Synchronises device interrupt lines into a registered pending vector for CP0.

Parameters:
- NUM_DEV, 3: number of attached devices (1..8).
- DEV_BASE, {32'h7f20, 32'h7f10, 32'h7f00}: flattened NUM_DEV*32; byte base address of device i at bits [32i+31:32i].
- DEV_LEN, {32'd12, 32'd12, 32'd12}: flattened NUM_DEV*32; window length in bytes.
- DEV_RO_ADDR, {32'd8, 32'd8, 32'd8}: flattened NUM_DEV*32; read-only offset within the window; a write there is an error.
- TIMEOUT, 15: maximum WAIT cycles before a bus error (1..255).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- vaddr  in  32  CPU byte address.
- type  in  MEM_TYPE_LEN  access size; only MEM_TYPE_WORD is legal.
- mode  in  MEM_MODE_LEN  MEM_MODE_READ, MEM_MODE_WRITE, or no access.
- wdata  in  32  CPU store data.
- int_req  in  1  CPU is taking an interrupt this cycle; a new access is dropped.
- stall  out  1  hold the memory stage.
- read_data  out  32  load result; valid in the DONE cycle.
- exc  out  EXC_CODE_LEN  0, EXC_CODE_ADEL or EXC_CODE_ADES.
- dev_addr  out  32  registered offset within the selected window.
- dev_wdata  out  32  registered store data.
- dev_we  out  1  registered write qualifier.
- dev_req  out  NUM_DEV  one-hot request, held until ack or timeout.
- dev_rdata  in  NUM_DEV*32  per-device read data.
- dev_ack  in  NUM_DEV  per-device completion; single-cycle pulse.
- dev_irq  in  NUM_DEV  raw device interrupt levels.
- irq_pending  out  NUM_DEV  dev_irq delayed by one flop.

Behaviour:
- Decode: sel_i = (vaddr >= BASE_i) && (vaddr < BASE_i + LEN_i), computed in 33-bit arithmetic so there is no wrap. When windows overlap, the lowest index wins.
- Static error: any of the following.
  - vaddr[1:0] != 0
  - type != WORD
  - no sel_i
  - mode==WRITE and offset==RO_ADDR_i
- States: IDLE, WAIT, DONE.
- IDLE, with mode != none:
  - Static error: exc = ADEL for a read, ADES for a write, combinationally in the same cycle; stall=0; no request; remain in IDLE.
  - Otherwise, int_req=1: the access is dropped; stall=0, exc=0; remain in IDLE.
  - Otherwise: stall=1 combinationally. Latch index, offset, wdata and we. Next cycle dev_req[idx]=1; go to WAIT; counter=0.
- WAIT:
  - stall=1; dev_req[idx] is held; counter increments each cycle.
  - dev_ack[idx]=1: read_data <= dev_rdata[idx] (0 for a write); go to DONE with exc=0.
  - counter == TIMEOUT-1 without ack: read_data <= 0; go to DONE with a registered exc (ADEL for a read, ADES for a write).
  - Ack on a non-selected index is ignored. int_req during WAIT does not cancel the transaction.
- DONE:
  - stall=0; read_data and the registered exc are visible for exactly one cycle; dev_req=0.
  - Always return to IDLE. The same CPU access is never relaunched.
- Latency: an accepted access stalls for 1 + ack_delay cycles. An ack in the first WAIT cycle gives 2 stall cycles and a DONE on the 3rd cycle after acceptance.
- irq_pending <= dev_irq every cycle; there is no latching beyond one flop.
- Reset (asynchronous, any state, including mid-WAIT):
  - state=IDLE; dev_req=0, dev_we=0, dev_addr=0, dev_wdata=0; read_data=0; registered exc=0; counter=0; irq_pending=0.
  - The device must tolerate a request that is abandoned mid-transaction.
- Outputs in IDLE with no access: stall=0, exc=0, read_data holds its last value.

Test Plan:
- Read 0x7f04: device 0 acks 2 cycles after req with 0xDEADBEEF -> stall high 3 cycles, read_data=0xDEADBEEF in DONE, exc=0, dev_addr=4.
- Write 0x7f18 (device 1, offset 8 = read-only) -> exc=ADES same cycle, stall=0, dev_req stays 0.
- Read 0x7f22 (misaligned), read 0x7f30 (unmapped), and a byte read of 0x7f00 -> each gives exc=ADEL, no request.
- Write 0x7f24 with no ack, TIMEOUT=15 -> dev_req held 15 cycles, then DONE with exc=ADES; next cycle IDLE.
- Write 0x7f00 with int_req=1 -> no dev_req, stall=0, exc=0. Then reset_n low during WAIT -> dev_req=0 and state IDLE asynchronously.
- dev_irq=3'b101 asserted -> irq_pending=3'b101 one cycle later; deasserting gives 0 one cycle later.

Source files
------------

// File: rtl/mmio_bridge_n.sv
// MMIO bridge: decodes CPU accesses onto NUM_DEV peripheral windows, runs a held
// req/ack handshake with timeout, and registers device interrupt lines for CP0.
module mmio_bridge_n #(
  parameter int                          NUM_DEV        = 3,
  parameter logic [NUM_DEV*32-1:0]       DEV_BASE       = {32'h7f20, 32'h7f10, 32'h7f00},
  parameter logic [NUM_DEV*32-1:0]       DEV_LEN        = {32'd12, 32'd12, 32'd12},
  parameter logic [NUM_DEV*32-1:0]       DEV_RO_ADDR    = {32'd8, 32'd8, 32'd8},
  parameter int                          TIMEOUT        = 15,
  parameter int                          MEM_TYPE_LEN   = 2,
  parameter logic [MEM_TYPE_LEN-1:0]     MEM_TYPE_WORD  = 2'd2,
  parameter int                          MEM_MODE_LEN   = 2,
  parameter logic [MEM_MODE_LEN-1:0]     MEM_MODE_READ  = 2'd1,
  parameter logic [MEM_MODE_LEN-1:0]     MEM_MODE_WRITE = 2'd2,
  parameter int                          EXC_CODE_LEN   = 5,
  parameter logic [EXC_CODE_LEN-1:0]     EXC_CODE_ADEL  = 5'd4,
  parameter logic [EXC_CODE_LEN-1:0]     EXC_CODE_ADES  = 5'd5
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [31:0]               vaddr,
  input  logic [MEM_TYPE_LEN-1:0]   mem_type,
  input  logic [MEM_MODE_LEN-1:0]   mode,
  input  logic [31:0]               wdata,
  input  logic                      int_req,
  output logic                      stall,
  output logic [31:0]               read_data,
  output logic [EXC_CODE_LEN-1:0]   exc,
  output logic [31:0]               dev_addr,
  output logic [31:0]               dev_wdata,
  output logic                      dev_we,
  output logic [NUM_DEV-1:0]        dev_req,
  input  logic [NUM_DEV*32-1:0]     dev_rdata,
  input  logic [NUM_DEV-1:0]        dev_ack,
  input  logic [NUM_DEV-1:0]        dev_irq,
  output logic [NUM_DEV-1:0]        irq_pending
);

  localparam int IDX_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e                    state_q;
  logic [IDX_W-1:0]          idx_q;
  logic [31:0]               dev_addr_q;
  logic [31:0]               dev_wdata_q;
  logic                      dev_we_q;
  logic [NUM_DEV-1:0]        dev_req_q;
  logic [7:0]                cnt_q;
  logic [31:0]               read_data_q;
  logic [EXC_CODE_LEN-1:0]   exc_q;
  logic [NUM_DEV-1:0]        irq_q;

  logic                      hit;
  logic [IDX_W-1:0]          sel_idx;
  logic [31:0]               base_sel;
  logic [31:0]               ro_sel;
  logic [31:0]               offset;
  logic                      is_rd;
  logic                      is_wr;
  logic                      access;
  logic                      static_err;
  logic                      launch;
  logic                      ack_sel;
  logic [31:0]               rdata_sel;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    logic [32:0] lo;
    logic [32:0] hi;
    hit      = 1'b0;
    sel_idx  = '0;
    base_sel = '0;
    ro_sel   = '0;
    lo       = '0;
    hi       = '0;
    for (int i = NUM_DEV - 1; i >= 0; i--) begin
      lo = {1'b0, DEV_BASE[32*i +: 32]};
      hi = lo + {1'b0, DEV_LEN[32*i +: 32]};
      if (({1'b0, vaddr} >= lo) && ({1'b0, vaddr} < hi)) begin
        hit      = 1'b1;
        sel_idx  = IDX_W'(i);
        base_sel = DEV_BASE[32*i +: 32];
        ro_sel   = DEV_RO_ADDR[32*i +: 32];
      end
    end
  end

  always_comb begin
    offset     = vaddr - base_sel;
    is_rd      = (mode == MEM_MODE_READ);
    is_wr      = (mode == MEM_MODE_WRITE);
    access     = is_rd || is_wr;
    static_err = (vaddr[1:0] != 2'b00) || (mem_type != MEM_TYPE_WORD) || !hit ||
                 (is_wr && (offset == ro_sel));
    launch     = (state_q == S_IDLE) && access && !static_err && !int_req;
  end

  // dev_req_q is one-hot on the latched index, so masking picks out the selected ack.
  always_comb begin
    ack_sel   = |(dev_ack & dev_req_q);
    rdata_sel = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (idx_q == IDX_W'(i)) rdata_sel = dev_rdata[32*i +: 32];
    end
  end

  always_comb begin
    stall = launch || (state_q == S_WAIT);
    exc   = '0;
    if ((state_q == S_IDLE) && access && static_err) begin
      exc = is_wr ? EXC_CODE_ADES : EXC_CODE_ADEL;
    end else if (state_q == S_DONE) begin
      exc = exc_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      dev_addr_q  <= '0;
      dev_wdata_q <= '0;
      dev_we_q    <= 1'b0;
      dev_req_q   <= '0;
      cnt_q       <= '0;
      read_data_q <= '0;
      exc_q       <= '0;
      irq_q       <= '0;
    end else begin
      irq_q <= dev_irq;
      case (state_q)
        S_IDLE: begin
          if (launch) begin
            idx_q       <= sel_idx;
            dev_addr_q  <= offset;
            dev_wdata_q <= wdata;
            dev_we_q    <= is_wr;
            dev_req_q   <= NUM_DEV'(1) << sel_idx;
            cnt_q       <= '0;
            exc_q       <= '0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (ack_sel) begin
            read_data_q <= dev_we_q ? 32'd0 : rdata_sel;
            exc_q       <= '0;
            dev_req_q   <= '0;
            state_q     <= S_DONE;
          end else if (cnt_q == 8'(TIMEOUT - 1)) begin
            read_data_q <= '0;
            exc_q       <= dev_we_q ? EXC_CODE_ADES : EXC_CODE_ADEL;
            dev_req_q   <= '0;
            state_q     <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_DONE: begin
          exc_q   <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign read_data   = read_data_q;
  assign dev_addr    = dev_addr_q;
  assign dev_wdata   = dev_wdata_q;
  assign dev_we      = dev_we_q;
  assign dev_req     = dev_req_q;
  assign irq_pending = irq_q;

endmodule

// File: tb/tb_mmio_bridge_n.sv
// Bench for mmio_bridge_n: directed scenarios plus randomized accesses scored
// against a transaction-level model of window decode, handshake and timeout.
module tb_mmio_bridge_n;

  localparam int          ND     = 3;
  localparam int          TO     = 15;
  localparam logic [1:0]  T_BYTE = 2'd0;
  localparam logic [1:0]  T_WORD = 2'd2;
  localparam logic [1:0]  M_NONE = 2'd0;
  localparam logic [1:0]  M_RD   = 2'd1;
  localparam logic [1:0]  M_WR   = 2'd2;
  localparam logic [4:0]  ADEL   = 5'd4;
  localparam logic [4:0]  ADES   = 5'd5;

  int unsigned mb[ND] = '{32'h7f00, 32'h7f10, 32'h7f20};
  int unsigned ml[ND] = '{12, 12, 12};
  int unsigned mr[ND] = '{8, 8, 8};

  logic             clk;
  logic             reset_n;
  logic [31:0]      vaddr;
  logic [1:0]       mem_type;
  logic [1:0]       mode;
  logic [31:0]      wdata;
  logic             int_req;
  logic             stall;
  logic [31:0]      read_data;
  logic [4:0]       exc;
  logic [31:0]      dev_addr;
  logic [31:0]      dev_wdata;
  logic             dev_we;
  logic [ND-1:0]    dev_req;
  logic [ND*32-1:0] dev_rdata;
  logic [ND-1:0]    dev_ack;
  logic [ND-1:0]    dev_irq;
  logic [ND-1:0]    irq_pending;

  int vec  = 0;
  int errs = 0;

  mmio_bridge_n #(
    .NUM_DEV(ND), .TIMEOUT(TO),
    .MEM_TYPE_LEN(2), .MEM_TYPE_WORD(T_WORD),
    .MEM_MODE_LEN(2), .MEM_MODE_READ(M_RD), .MEM_MODE_WRITE(M_WR),
    .EXC_CODE_LEN(5), .EXC_CODE_ADEL(ADEL), .EXC_CODE_ADES(ADES)
  ) dut (
    .clk(clk), .reset_n(reset_n), .vaddr(vaddr), .mem_type(mem_type), .mode(mode),
    .wdata(wdata), .int_req(int_req), .stall(stall), .read_data(read_data), .exc(exc),
    .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_we(dev_we), .dev_req(dev_req),
    .dev_rdata(dev_rdata), .dev_ack(dev_ack), .dev_irq(dev_irq), .irq_pending(irq_pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void ref_decode(input logic [31:0] a, input logic [1:0] t,
                                     input logic [1:0] m, output bit err,
                                     output int idx, output logic [31:0] off);
    longint la;
    la  = longint'({32'd0, a});
    idx = -1;
    off = 0;
    for (int i = 0; i < ND; i++) begin
      if (idx < 0 && la >= longint'(mb[i]) && la < longint'(mb[i]) + longint'(ml[i])) idx = i;
    end
    if (idx >= 0) off = a - mb[idx];
    err = (a % 4 != 0) || (t != T_WORD) || (idx < 0) || (m == M_WR && idx >= 0 && off == mr[idx]);
  endfunction

  task automatic do_access(input string tag, input logic [31:0] a, input logic [1:0] t,
                           input logic [1:0] m, input logic [31:0] wd, input bit intr,
                           input int ack_delay, input bit noisy, input bit use_fixed,
                           input logic [31:0] fixed_val);
    bit          err;
    int          idx;
    logic [31:0] off;
    logic [4:0]  exp_exc;
    logic [31:0] exp_rd;
    logic [ND-1:0] oh;
    int          exp_wait;
    int          nstall;
    ref_decode(a, t, m, err, idx, off);
    @(negedge clk);
    vaddr = a; mem_type = t; mode = m; wdata = wd; int_req = intr; dev_ack = '0;
    #1;
    if (err || intr) begin
      exp_exc = err ? ((m == M_WR) ? ADES : ADEL) : 5'd0;
      vec++;
      if (stall !== 1'b0 || exc !== exp_exc) begin
        errs++;
        $display("FAIL %s reject: stall=%0b exc=%0d, want stall=0 exc=%0d", tag, stall, exc, exp_exc);
      end
      @(negedge clk);
      mode = M_NONE; int_req = 1'b0;
      #1;
      vec++;
      if (dev_req !== '0 || stall !== 1'b0 || exc !== 5'd0) begin
        errs++;
        $display("FAIL %s no_req: dev_req=%b stall=%0b exc=%0d, want 000/0/0", tag, dev_req, stall, exc);
      end
      return;
    end
    vec++;
    if (stall !== 1'b1 || exc !== 5'd0) begin
      errs++;
      $display("FAIL %s accept: stall=%0b exc=%0d, want stall=1 exc=0", tag, stall, exc);
    end
    oh       = ND'(1) << idx;
    nstall   = 1;
    exp_rd   = 32'd0;
    exp_wait = (ack_delay >= 1 && ack_delay <= TO) ? ack_delay : TO;
    for (int w = 1; w <= TO; w++) begin
      @(negedge clk);
      dev_ack   = '0;
      int_req   = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      dev_rdata = {$urandom, $urandom, $urandom};
      if (use_fixed) dev_rdata[32*idx +: 32] = fixed_val;
      #1;
      if (stall === 1'b1) nstall++;
      vec++;
      if (dev_req !== oh || dev_addr !== off || dev_we !== (m == M_WR) || dev_wdata !== wd) begin
        errs++;
        $display("FAIL %s wait%0d: req=%b addr=%h we=%b wd=%h, want req=%b addr=%h we=%b wd=%h",
                 tag, w, dev_req, dev_addr, dev_we, dev_wdata, oh, off, (m == M_WR), wd);
      end
      if (w == ack_delay) begin
        dev_ack = oh;
        exp_rd  = (m == M_RD) ? dev_rdata[32*idx +: 32] : 32'd0;
      end else begin
        dev_ack = noisy ? (ND'($urandom_range(0, 7)) & ~oh) : '0;
      end
      if (w == exp_wait) break;
    end
    @(negedge clk);
    dev_ack = '0; int_req = 1'b0;
    #1;
    exp_exc = (exp_wait == ack_delay) ? 5'd0 : ((m == M_WR) ? ADES : ADEL);
    vec++;
    if (stall !== 1'b0 || dev_req !== '0) begin
      errs++;
      $display("FAIL %s done_ctl: stall=%0b req=%b, want 0/000", tag, stall, dev_req);
    end
    vec++;
    if (read_data !== exp_rd || exc !== exp_exc) begin
      errs++;
      $display("FAIL %s done_data: rd=%h exc=%0d, want rd=%h exc=%0d", tag, read_data, exc, exp_rd, exp_exc);
    end
    vec++;
    if (nstall !== 1 + exp_wait) begin
      errs++;
      $display("FAIL %s stall_len: got %0d cycles, want %0d", tag, nstall, 1 + exp_wait);
    end
    @(negedge clk);
    mode = M_NONE;
    #1;
    vec++;
    if (dev_req !== '0 || stall !== 1'b0 || exc !== 5'd0 || read_data !== exp_rd) begin
      errs++;
      $display("FAIL %s idle_after: req=%b stall=%0b exc=%0d rd=%h, want 000/0/0/%h",
               tag, dev_req, stall, exc, read_data, exp_rd);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; vaddr = '0; mem_type = T_WORD; mode = M_NONE; wdata = '0; int_req = 1'b0;
    dev_rdata = '0; dev_ack = '0; dev_irq = '0;
    #12;
    vec++;
    if (stall !== 1'b0 || exc !== 5'd0 || read_data !== 32'd0 || dev_req !== '0 ||
        dev_addr !== 32'd0 || dev_wdata !== 32'd0 || dev_we !== 1'b0 || irq_pending !== '0) begin
      errs++;
      $display("FAIL reset_state: stall=%0b exc=%0d rd=%h req=%b addr=%h wd=%h we=%b irq=%b, want all 0",
               stall, exc, read_data, dev_req, dev_addr, dev_wdata, dev_we, irq_pending);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_read_ack();
    do_access("rd_7f04", 32'h7f04, T_WORD, M_RD, 32'h0, 1'b0, 2, 1'b0, 1'b1, 32'hDEADBEEF);
    do_access("rd_7f14_fast", 32'h7f14, T_WORD, M_RD, 32'h0, 1'b0, 1, 1'b0, 1'b1, 32'h12345678);
    do_access("wr_7f10_ack", 32'h7f10, T_WORD, M_WR, 32'hCAFEF00D, 1'b0, 3, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_static_errors();
    do_access("wr_ro_7f18", 32'h7f18, T_WORD, M_WR, 32'h1, 1'b0, 1, 1'b0, 1'b0, 32'h0);
    do_access("rd_misalign", 32'h7f22, T_WORD, M_RD, 32'h0, 1'b0, 1, 1'b0, 1'b0, 32'h0);
    do_access("rd_unmapped", 32'h7f30, T_WORD, M_RD, 32'h0, 1'b0, 1, 1'b0, 1'b0, 32'h0);
    do_access("rd_byte", 32'h7f00, T_BYTE, M_RD, 32'h0, 1'b0, 1, 1'b0, 1'b0, 32'h0);
    do_access("rd_ro_ok", 32'h7f28, T_WORD, M_RD, 32'h0, 1'b0, 1, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_timeout();
    do_access("wr_timeout", 32'h7f24, T_WORD, M_WR, 32'h55AA55AA, 1'b0, 0, 1'b0, 1'b0, 32'h0);
    do_access("rd_ack_last", 32'h7f08, T_WORD, M_RD, 32'h0, 1'b0, TO, 1'b0, 1'b1, 32'hA5A5A5A5);
  endtask

  task automatic test_int_req();
    do_access("wr_intreq", 32'h7f00, T_WORD, M_WR, 32'h77, 1'b1, 1, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    vaddr = 32'h7f00; mem_type = T_WORD; mode = M_WR; wdata = 32'h0BADF00D; int_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    vec++;
    if (dev_req !== 3'b001 || stall !== 1'b1) begin
      errs++;
      $display("FAIL rst_wait_pre: req=%b stall=%0b, want 001/1", dev_req, stall);
    end
    #1;
    reset_n = 1'b0; mode = M_NONE;
    #1;
    vec++;
    if (dev_req !== '0 || stall !== 1'b0 || dev_addr !== 32'd0 || dev_we !== 1'b0 ||
        dev_wdata !== 32'd0 || read_data !== 32'd0 || exc !== 5'd0) begin
      errs++;
      $display("FAIL rst_wait_async: req=%b stall=%0b addr=%h we=%b wd=%h rd=%h exc=%0d, want all 0",
               dev_req, stall, dev_addr, dev_we, dev_wdata, read_data, exc);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    vec++;
    if (dev_req !== '0 || stall !== 1'b0) begin
      errs++;
      $display("FAIL rst_wait_after: req=%b stall=%0b, want 000/0", dev_req, stall);
    end
    do_access("post_rst_rd", 32'h7f04, T_WORD, M_RD, 32'h0, 1'b0, 1, 1'b0, 1'b1, 32'h600D600D);
  endtask

  task automatic test_irq();
    logic [ND-1:0] prev;
    @(negedge clk);
    dev_irq = 3'b101;
    #1;
    vec++;
    if (irq_pending !== 3'b000) begin
      errs++;
      $display("FAIL irq_early: got %b, want 000", irq_pending);
    end
    @(negedge clk);
    #1;
    vec++;
    if (irq_pending !== 3'b101) begin
      errs++;
      $display("FAIL irq_set: got %b, want 101", irq_pending);
    end
    dev_irq = 3'b000;
    @(negedge clk);
    #1;
    vec++;
    if (irq_pending !== 3'b000) begin
      errs++;
      $display("FAIL irq_clr: got %b, want 000", irq_pending);
    end
    prev = 3'b000;
    for (int k = 0; k < 8; k++) begin
      dev_irq = ND'($urandom_range(0, 7));
      @(negedge clk);
      #1;
      vec++;
      if (irq_pending !== dev_irq) begin
        errs++;
        $display("FAIL irq_rand%0d: got %b, want %b", k, irq_pending, dev_irq);
      end
      prev = dev_irq;
    end
    dev_irq = '0;
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [1:0]  t;
    logic [1:0]  m;
    bit          intr;
    int          ad;
    for (int n = 0; n < 40; n++) begin
      a = 32'h7f00 + 32'($urandom_range(0, 13)) * 4;
      if ($urandom_range(0, 5) == 0) a = a + 32'($urandom_range(1, 3));
      t = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 1)) : T_WORD;
      m = ($urandom_range(0, 1) == 0) ? M_RD : M_WR;
      intr = ($urandom_range(0, 5) == 0);
      ad = $urandom_range(0, TO + 2);
      do_access($sformatf("rand%0d", n), a, t, m, $urandom, intr, ad, 1'b1, 1'b0, 32'h0);
    end
  endtask

  initial begin
    test_reset();
    test_read_ack();
    test_static_errors();
    test_timeout();
    test_int_req();
    test_reset_mid_wait();
    test_irq();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
